// File: rtl/fsm_slave.sv
// Bit-level serial target (I2C-style, configurable bit order): synchronizes SCL/SDA,
// detects START/STOP, decodes its address and moves bytes in both directions.
module fsm_slave #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'b1011010,
  parameter int         LSB_FIRST     = 1
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic       sda_select,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic [2:0] state_dbg_o
);

  // Handshake: rx_valid and tx_req are single-clk strobes; no back-pressure exists.
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t     state_q;
  logic       scl_s1_q, scl_s2_q, scl_d1_q;
  logic       sda_s1_q, sda_s2_q, sda_d1_q;
  logic [2:0] cnt_q;
  logic [7:0] sh_q;
  logic [7:0] txb_q;
  logic       rw_q;
  logic       ack_seen_q;
  logic       sel_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_req_q;
  logic       busy_q;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] sh_d;
  logic [6:0] addr_d;
  logic       rw_d;

  function automatic logic tx_bit(input logic [7:0] b, input logic [2:0] i);
    return (LSB_FIRST != 0) ? b[i] : b[3'd7 - i];
  endfunction

  assign scl_rise  = scl_s2_q & ~scl_d1_q;
  assign scl_fall  = ~scl_s2_q & scl_d1_q;
  // Require SCL high on both samples so an SDA change at an SCL edge is never a START/STOP.
  assign start_det = sda_d1_q & ~sda_s2_q & scl_s2_q & scl_d1_q;
  assign stop_det  = ~sda_d1_q & sda_s2_q & scl_s2_q & scl_d1_q;

  assign sh_d   = (LSB_FIRST != 0) ? {sda_s2_q, sh_q[7:1]} : {sh_q[6:0], sda_s2_q};
  assign addr_d = (LSB_FIRST != 0) ? sh_d[6:0] : sh_d[7:1];
  assign rw_d   = (LSB_FIRST != 0) ? sh_d[7] : sh_d[0];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_d1_q   <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_d1_q   <= 1'b1;
      cnt_q      <= 3'd0;
      sh_q       <= 8'h00;
      txb_q      <= 8'h00;
      rw_q       <= 1'b0;
      ack_seen_q <= 1'b0;
      sel_q      <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_s1_q   <= scl_in;
      scl_s2_q   <= scl_s1_q;
      scl_d1_q   <= scl_s2_q;
      sda_s1_q   <= sda_in;
      sda_s2_q   <= sda_s1_q;
      sda_d1_q   <= sda_s2_q;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (start_det) begin
        state_q    <= ADDR;
        cnt_q      <= 3'd0;
        sel_q      <= 1'b0;
        busy_q     <= 1'b0;
        ack_seen_q <= 1'b0;
      end else if (stop_det) begin
        state_q    <= IDLE;
        cnt_q      <= 3'd0;
        sel_q      <= 1'b0;
        busy_q     <= 1'b0;
        ack_seen_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR: begin
            if (scl_rise) begin
              sh_q  <= sh_d;
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                if (addr_d == SLAVE_ADDRESS) begin
                  state_q  <= ADDR_ACK;
                  busy_q   <= 1'b1;
                  rw_q     <= rw_d;
                  tx_req_q <= rw_d;
                end else begin
                  state_q <= WAIT_STOP;
                end
              end
            end
          end
          // First fall after the byte starts the ACK, the second one ends it.
          ADDR_ACK, RX_ACK: begin
            if (scl_fall) begin
              if (!sel_q) begin
                sel_q <= 1'b1;
              end else if (state_q == RX_ACK || !rw_q) begin
                sel_q   <= 1'b0;
                state_q <= RX;
              end else begin
                txb_q   <= tx_data;
                sel_q   <= ~tx_bit(tx_data, 3'd0);
                cnt_q   <= 3'd0;
                state_q <= TX;
              end
            end
          end
          RX: begin
            if (scl_rise) begin
              sh_q  <= sh_d;
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                rx_data_q  <= sh_d;
                rx_valid_q <= 1'b1;
                state_q    <= RX_ACK;
              end
            end
          end
          // cnt_q counts rising edges; once it wraps to 0 all 8 bits have been clocked out.
          TX: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 3'd1;
            end else if (scl_fall) begin
              if (cnt_q == 3'd0) begin
                sel_q   <= 1'b0;
                state_q <= TX_ACK;
              end else begin
                sel_q <= ~tx_bit(txb_q, cnt_q);
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (!sda_s2_q) begin
                ack_seen_q <= 1'b1;
                tx_req_q   <= 1'b1;
              end else begin
                sel_q   <= 1'b0;
                state_q <= WAIT_STOP;
              end
            end else if (scl_fall && ack_seen_q) begin
              ack_seen_q <= 1'b0;
              txb_q      <= tx_data;
              sel_q      <= ~tx_bit(tx_data, 3'd0);
              cnt_q      <= 3'd0;
              state_q    <= TX;
            end
          end
          WAIT_STOP: sel_q <= 1'b0;
          default:   sel_q <= 1'b0;
        endcase
      end
    end
  end

  assign sda_out     = 1'b0;
  assign sda_select  = sel_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_req      = tx_req_q;
  assign busy        = busy_q;
  assign state_dbg_o = state_q;

endmodule
